// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: bus register map, FSM states
// and helpers that size the internal registers for the configured source count.
package irq_pkg;

    localparam logic [23:0] IRQ_PRIO0 = 24'h002020;
    localparam logic [23:0] IRQ_PRIO1 = 24'h002021;
    localparam logic [23:0] IRQ_EN0   = 24'h002023;
    localparam logic [23:0] IRQ_EN1   = 24'h002024;
    localparam logic [23:0] IRQ_EN2   = 24'h002025;
    localparam logic [23:0] IRQ_EN3   = 24'h002026;
    localparam logic [23:0] IRQ_FLAG0 = 24'h002027;
    localparam logic [23:0] IRQ_FLAG1 = 24'h002028;
    localparam logic [23:0] IRQ_FLAG2 = 24'h002029;
    localparam logic [23:0] IRQ_FLAG3 = 24'h00202A;

    localparam int MAX_SOURCES = 32;
    localparam int MAX_GROUPS  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } fsm_state_t;

    function automatic int num_groups(input int num_sources);
        return num_sources / 4;
    endfunction

    // Registers are always held at full width; bits of absent sources stay zero.
    function automatic logic [31:0] source_mask(input int num_sources);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < MAX_SOURCES; i++)
            if (i < num_sources) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [15:0] prio_mask(input int groups);
        logic [15:0] m;
        m = '0;
        for (int g = 0; g < MAX_GROUPS; g++)
            if (g < groups) m[2*g +: 2] = 2'b11;
        return m;
    endfunction

endpackage

// File: rtl/irq_controller_arbiter.sv
// Combinational priority arbiter: highest group priority above cpu_mask wins,
// lowest source index breaks ties.
module irq_arbiter
    import irq_pkg::*;
(
    input  logic [MAX_SOURCES-1:0]  flags,
    input  logic [MAX_SOURCES-1:0]  enables,
    input  logic [2*MAX_GROUPS-1:0] prio,
    input  logic [1:0]              cpu_mask,
    output logic [4:0]              win_index,
    output logic [1:0]              win_level,
    output logic                    win_valid
);

    logic [1:0] src_level;

    // Ascending scan with a strict compare keeps the lowest index on a tie.
    always_comb begin
        win_index = '0;
        win_level = '0;
        win_valid = 1'b0;
        src_level = '0;
        for (int i = 0; i < MAX_SOURCES; i++) begin
            src_level = prio[2*(i/4) +: 2];
            if (flags[i] && enables[i] && (src_level > cpu_mask) &&
                (!win_valid || (src_level > win_level))) begin
                win_valid = 1'b1;
                win_level = src_level;
                win_index = 5'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller top: bus-visible priority/enable/flag registers, a registered
// arbitration stage and the request/acknowledge handshake towards the CPU.
module irq_controller
    import irq_pkg::*;
#(
    parameter int NUM_SOURCES = 32,
    parameter int VECTOR_BASE = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   bus_write,
    input  logic                   bus_read,
    input  logic [23:0]            bus_address_in,
    input  logic [7:0]             bus_data_in,
    output logic [7:0]             bus_data_out,
    input  logic [NUM_SOURCES-1:0] irq_in,
    input  logic [1:0]             cpu_mask,
    input  logic                   cpu_irq_ack,
    output logic                   irq_req,
    output logic [5:0]             irq_vector,
    output logic [1:0]             irq_level
);

    localparam logic [31:0] SRC_MASK  = source_mask(NUM_SOURCES);
    localparam logic [15:0] PRIO_MASK = prio_mask(num_groups(NUM_SOURCES));

    logic [15:0] prio_q, prio_next;
    logic [31:0] enable_q, enable_next;
    logic [31:0] flag_q, flag_clear, irq_ext;
    logic [4:0]  win_index, win_index_q;
    logic [1:0]  win_level, win_level_q;
    logic        win_valid, win_valid_q;
    fsm_state_t  state;
    logic [4:0]  src_q;
    logic [1:0]  src_prio;
    logic        src_eligible;

    assign irq_ext = 32'(irq_in);

    always_comb begin
        prio_next   = prio_q;
        enable_next = enable_q;
        flag_clear  = '0;
        if (bus_write) begin
            case (bus_address_in)
                IRQ_PRIO0: prio_next[7:0]    = bus_data_in;
                IRQ_PRIO1: prio_next[15:8]   = bus_data_in;
                IRQ_EN0:   enable_next[7:0]  = bus_data_in;
                IRQ_EN1:   enable_next[15:8] = bus_data_in;
                IRQ_EN2:   enable_next[23:16] = bus_data_in;
                IRQ_EN3:   enable_next[31:24] = bus_data_in;
                IRQ_FLAG0: flag_clear[7:0]   = bus_data_in;
                IRQ_FLAG1: flag_clear[15:8]  = bus_data_in;
                IRQ_FLAG2: flag_clear[23:16] = bus_data_in;
                IRQ_FLAG3: flag_clear[31:24] = bus_data_in;
                default: ;
            endcase
        end
    end

    // New pulses are ORed in after the clear so a colliding set wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q   <= '0;
            enable_q <= '0;
            flag_q   <= '0;
        end else begin
            prio_q   <= prio_next & PRIO_MASK;
            enable_q <= enable_next & SRC_MASK;
            flag_q   <= ((flag_q & ~flag_clear) | irq_ext) & SRC_MASK;
        end
    end

    always_comb begin
        bus_data_out = '0;
        if (bus_read) begin
            case (bus_address_in)
                IRQ_PRIO0: bus_data_out = prio_q[7:0];
                IRQ_PRIO1: bus_data_out = prio_q[15:8];
                IRQ_EN0:   bus_data_out = enable_q[7:0];
                IRQ_EN1:   bus_data_out = enable_q[15:8];
                IRQ_EN2:   bus_data_out = enable_q[23:16];
                IRQ_EN3:   bus_data_out = enable_q[31:24];
                IRQ_FLAG0: bus_data_out = flag_q[7:0];
                IRQ_FLAG1: bus_data_out = flag_q[15:8];
                IRQ_FLAG2: bus_data_out = flag_q[23:16];
                IRQ_FLAG3: bus_data_out = flag_q[31:24];
                default:   bus_data_out = '0;
            endcase
        end
    end

    irq_arbiter u_arbiter (
        .flags     (flag_q),
        .enables   (enable_q),
        .prio      (prio_q),
        .cpu_mask  (cpu_mask),
        .win_index (win_index),
        .win_level (win_level),
        .win_valid (win_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            win_index_q <= '0;
            win_level_q <= '0;
            win_valid_q <= 1'b0;
        end else begin
            win_index_q <= win_index;
            win_level_q <= win_level;
            win_valid_q <= win_valid;
        end
    end

    // Live eligibility of the source currently being presented, used for withdrawal.
    assign src_prio     = prio_q[{src_q[4:2], 1'b0} +: 2];
    assign src_eligible = flag_q[src_q] & enable_q[src_q] & (src_prio > cpu_mask);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            irq_req    <= 1'b0;
            irq_vector <= '0;
            irq_level  <= '0;
            src_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid_q) begin
                        state      <= REQ;
                        irq_req    <= 1'b1;
                        irq_vector <= 6'(VECTOR_BASE) + {1'b0, win_index_q};
                        irq_level  <= win_level_q;
                        src_q      <= win_index_q;
                    end
                end
                REQ: begin
                    if (cpu_irq_ack) begin
                        state   <= ACK;
                        irq_req <= 1'b0;
                    end else if (!src_eligible) begin
                        state   <= IDLE;
                        irq_req <= 1'b0;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    irq_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
